// File: rtl/hp_mdu.sv
// hp_mdu: iterative RV32M/RV64M multiply/divide unit for the hp core EX stage.
// Define HP_MDU_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module hp_mdu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [RD_W-1:0] req_rd,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN-1);
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  state_e state, state_nxt;

  logic [2:0]        op;
  logic [RD_W-1:0]   rd;
  logic [XLEN-1:0]   m;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic [CW-1:0]     cnt;

  logic              accept, is_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, m_init;
  logic [2*XLEN-1:0] acc_init;

  always_comb begin
    accept   = req_valid && (state == IDLE) && !kill;
    is_div   = req_op[2];
    sgn_a    = is_div ? !req_op[0] : (req_op[1:0] == 2'b01 || req_op[1:0] == 2'b10);
    sgn_b    = is_div ? !req_op[0] : (req_op[1:0] == 2'b01);
    neg_a    = sgn_a && req_a[XLEN-1];
    neg_b    = sgn_b && req_b[XLEN-1];
    a_mag    = neg_a ? -req_a : req_a;
    b_mag    = neg_b ? -req_b : req_b;
    b_zero   = (req_b == '0);
    ovf      = is_div && !req_op[0] && (req_a == MIN) && (req_b == '1);
    special  = is_div && (b_zero || ovf);
    if (b_zero) special_res = req_op[1] ? req_a : '1;
    else        special_res = req_op[1] ? '0 : MIN;
    // Divide: acc = {remainder, dividend}; multiply: acc = {partial, multiplier}.
    acc_init = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
    m_init   = is_div ? b_mag : a_mag;
  end

  // One iteration step; in IDLE it runs on the incoming operands so the
  // accepting edge already performs the first of the XLEN steps.
  logic [2*XLEN-1:0] src_acc, step;
  logic [XLEN-1:0]   src_m;
  logic [XLEN:0]     trial, diff;
`ifndef HP_MDU_FAST_MUL_EN
  logic              src_div;
  logic [XLEN:0]     sum;
`endif

  always_comb begin
    src_acc = (state == IDLE) ? acc_init : acc;
    src_m   = (state == IDLE) ? m_init : m;
    trial   = {src_acc[2*XLEN-1:XLEN], src_acc[XLEN-1]};
    diff    = trial - {1'b0, src_m};
    step    = diff[XLEN] ? {trial[XLEN-1:0], src_acc[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0],  src_acc[XLEN-2:0], 1'b1};
`ifndef HP_MDU_FAST_MUL_EN
    src_div = (state == IDLE) ? is_div : (state == DIV);
    sum     = {1'b0, src_acc[2*XLEN-1:XLEN]} + (src_acc[0] ? {1'b0, src_m} : '0);
    if (!src_div) step = {sum, src_acc[XLEN-1:1]};
`endif
  end

  function automatic logic [XLEN-1:0] finish(input logic [2:0] f_op, input logic [2*XLEN-1:0] f_acc,
                                             input logic f_nq, input logic f_nr);
    logic [2*XLEN-1:0] p;
    p = f_nq ? -f_acc : f_acc;
    case (f_op)
      3'b000, 3'b100, 3'b101: return p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: return p[2*XLEN-1:XLEN];
      default:                return f_nr ? -f_acc[2*XLEN-1:XLEN] : f_acc[2*XLEN-1:XLEN];
    endcase
  endfunction

`ifdef HP_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op <= '0; rd <= '0; m <= '0; acc <= '0; cnt <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; resp_data <= '0;
    end else if (accept) begin
      op    <= req_op;
      rd    <= req_rd;
      m     <= m_init;
      acc   <= step;
      cnt   <= CW'(1);
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      if (special) resp_data <= special_res;
`ifdef HP_MDU_FAST_MUL_EN
      else if (!is_div) resp_data <= finish(req_op, fast_prod, neg_a ^ neg_b, neg_a);
`endif
    end else if (kill) begin
      cnt <= '0;
    end else if (state == MUL || state == DIV) begin
      acc <= step;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        resp_data <= finish(op, step, neg_q, neg_r);
        cnt       <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
    if (kill) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (accept) begin
          if (special)     state_nxt = DONE;
          else if (is_div) state_nxt = DIV;
`ifdef HP_MDU_FAST_MUL_EN
          else             state_nxt = DONE;
`else
          else             state_nxt = MUL;
`endif
        end
        MUL, DIV: if (cnt == LAST) state_nxt = DONE;
        DONE:     if (resp_ready) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  assign resp_rd = rd;

endmodule

// File: tb/tb_hp_mdu.sv
// tb_hp_mdu: scoreboard bench for hp_mdu (XLEN=32): directed RV M cases, random ops, kill, backpressure.
module tb_hp_mdu;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
`ifdef HP_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN;
`endif
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic            clk = 1'b0, rst = 1'b1, req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b1;
  logic            req_ready, resp_valid, busy;
  logic [2:0]      req_op = '0;
  logic [XLEN-1:0] req_a = '0, req_b = '0, resp_data;
  logic [RD_W-1:0] req_rd = '0, resp_rd;

  hp_mdu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .kill(kill), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd), .busy(busy)
  );

  typedef struct { logic [31:0] data; logic [4:0] rd; int due; } sb_t;
  sb_t sb_q[$];
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, sa, sb, ua, ub;
    logic ov;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    ov = (a == MINV) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? MINV : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0 || (!op[0] && a == MINV && b == 32'hFFFF_FFFF)) return 1;
    return XLEN;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic put(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, output int acc);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_ready", req_ready, 1);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int acc;
    put(op, a, b, rd, acc);
    sb_q.push_back('{exp, rd, acc + lat});
  endtask

  task automatic recv(input string tag);
    int n = 0;
    sb_t e;
    while (!resp_valid && n < 300) begin @(negedge clk); n++; end
    if (sb_q.size() == 0) begin chk({tag, "_sb_empty"}, 1, 0); return; end
    e = sb_q.pop_front();
    if (!resp_valid) begin chk({tag, "_timeout"}, 0, 1); return; end
    chk({tag, "_data"}, resp_data, e.data);
    chk({tag, "_rd"}, resp_rd, e.rd);
    chk({tag, "_lat"}, cyc, e.due);
    @(negedge clk);
    chk({tag, "_idle"}, req_ready, 1);
  endtask

  initial begin
    int acc, n;
    bit seen;
    sb_t e;
    logic [2:0] op;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_rd", resp_rd, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    send(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MUL_LAT);        recv("mul");
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MUL_LAT); recv("mulhu");
    send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0, MUL_LAT);         recv("mulh");
    send(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, MUL_LAT);         recv("mulhsu");
    send(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, XLEN);            recv("div");
    send(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, XLEN);            recv("rem");
    send(3'b101, 32'd100, 32'd7, 5'd7, 32'd14, XLEN);                         recv("divu");
    send(3'b111, 32'd100, 32'd7, 5'd8, 32'd2, XLEN);                          recv("remu");
    send(3'b101, 32'd13, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);                      recv("divu0");
    send(3'b111, 32'd13, 32'd0, 5'd10, 32'd13, 1);                            recv("remu0");
    send(3'b100, MINV, 32'hFFFF_FFFF, 5'd11, MINV, 1);                        recv("div_ovf");
    send(3'b110, MINV, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);                       recv("rem_ovf");
    send(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);              recv("div0");
    send(3'b001, MINV, MINV, 5'd14, 32'h4000_0000, MUL_LAT);                  recv("mulh_min");

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      send(op, a, b, 5'(i), model(op, a, b), lat_of(op, a, b));
      recv("rand");
    end

    // Flush at iteration 10 of a divide.
    put(3'b100, 32'd1000, 32'd3, 5'd20, acc);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", req_ready, 1);
    chk("kill_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    chk("kill_no_resp", seen, 0);

    // kill alongside a request in IDLE blocks the accept.
    req_valid = 1'b1; req_op = 3'b101; req_a = 32'd50; req_b = 32'd5; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_busy", busy, 0);
    chk("kill_idle_ready", req_ready, 1);

    // Backpressure in DONE with the next request already waiting.
    resp_ready = 1'b0;
    send(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, XLEN);
    n = 0;
    while (!resp_valid && n < 300) begin @(negedge clk); n++; end
    e = sb_q.pop_front();
    chk("bp_first_valid", resp_valid, 1);
    chk("bp_first_lat", cyc, e.due);
    req_valid = 1'b1; req_op = 3'b111; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd4;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, e.data);
      chk("bp_rd", resp_rd, e.rd);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready", req_ready, 1);
    chk("bp_drop", resp_valid, 0);
    sb_q.push_back('{32'd2, 5'd4, cyc + XLEN});
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_accept", busy, 1);
    recv("bp_next");

    // Asynchronous reset in the middle of a divide.
    put(3'b100, 32'd1000, 32'd3, 5'd9, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", resp_data, 0);
    chk("rst_mid_rd", resp_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    chk("rst_mid_no_resp", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
